// File: rtl/cache_pkg.sv
// Shared L1 cache definitions: geometry constants, way/set types and the
// flush engine state encoding.
package cache_pkg;

  localparam int SETS = 8192;
  localparam int WAYS = 4;
  localparam int AW   = 13;
  localparam int CW   = 16;

  typedef logic [1:0]    way_t;
  typedef logic [AW-1:0] set_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    SCAN  = 3'd2,
    ISSUE = 3'd3,
    CLEAR = 3'd4,
    NEXT  = 3'd5,
    DONE  = 3'd6
  } flush_state_t;

endpackage

// File: rtl/dirty_flush_if.sv
// Dirty-bit regfile port plus writeback request channel of the flush engine.
// The master side is the flush engine; the slave side is the regfile and memory.
interface dirty_flush_if #(
  parameter int AW   = 13,
  parameter int WAYS = 4
);

  logic [AW-1:0]   dirty_ra;
  logic [WAYS-1:0] dirty_rd;
  logic [AW-1:0]   dirty_wa;
  logic [WAYS-1:0] dirty_way;
  logic            dirty_wr;
  logic            dirty_in;
  logic            wb_req;
  logic [AW-1:0]   wb_set;
  logic [1:0]      wb_way;
  logic            wb_ack;

  modport master (
    output dirty_ra, dirty_wa, dirty_way, dirty_wr, dirty_in,
    output wb_req, wb_set, wb_way,
    input  dirty_rd, wb_ack
  );

  modport slave (
    input  dirty_ra, dirty_wa, dirty_way, dirty_wr, dirty_in,
    input  wb_req, wb_set, wb_way,
    output dirty_rd, wb_ack
  );

endinterface

// File: rtl/way_pick.sv
// Lowest-set-bit priority encoder over a way vector: index, one-hot and valid.
// Shared between the flush engine and victim selection.
module way_pick #(
  parameter int WAYS = 4,
  parameter int IW   = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic [WAYS-1:0] vec,
  output logic [IW-1:0]   idx,
  output logic [WAYS-1:0] onehot,
  output logic            valid
);

  // Walk from the top down so the lowest set bit is the last one to win.
  always_comb begin
    idx    = '0;
    onehot = '0;
    valid  = 1'b0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx       = IW'(i);
        onehot    = '0;
        onehot[i] = 1'b1;
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dirty_flush.sv
// L1 flush engine: walks every set, writes back each dirty way and clears
// its dirty bit once memory has acknowledged the request.
module dirty_flush
  import cache_pkg::*;
#(
  parameter int SETS = cache_pkg::SETS,
  parameter int WAYS = cache_pkg::WAYS,
  parameter int AW   = cache_pkg::AW,
  parameter int CW   = cache_pkg::CW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          flush_start,
  output logic          flush_busy,
  output logic          flush_done,
  output logic [CW-1:0] wb_count,
  dirty_flush_if.master bus
);

  localparam logic [AW-1:0] LAST_SET = AW'(SETS - 1);

  flush_state_t    state;
  logic [AW-1:0]   set_ctr;
  logic [WAYS-1:0] pend;
  way_t            way_sel;
  logic [WAYS-1:0] way_sel_oh;

  logic [WAYS-1:0] pick_in;
  way_t            pick_idx;
  logic [WAYS-1:0] pick_oh;
  logic            pick_valid;

  // In CLEAR the encoder already sees pend without the way being cleared,
  // so the next dirty way issues straight from CLEAR with no extra SCAN.
  assign pick_in = (state == CLEAR) ? (pend & ~way_sel_oh) : pend;

  way_pick #(
    .WAYS (WAYS),
    .IW   (2)
  ) u_way_pick (
    .vec    (pick_in),
    .idx    (pick_idx),
    .onehot (pick_oh),
    .valid  (pick_valid)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      set_ctr    <= '0;
      pend       <= '0;
      way_sel    <= '0;
      way_sel_oh <= '0;
      wb_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (flush_start) begin
            set_ctr  <= '0;
            wb_count <= '0;
            state    <= READ;
          end
        end
        READ: begin
          pend  <= bus.dirty_rd;
          state <= SCAN;
        end
        SCAN: begin
          if (pick_valid) begin
            way_sel    <= pick_idx;
            way_sel_oh <= pick_oh;
            state      <= ISSUE;
          end else begin
            state <= NEXT;
          end
        end
        ISSUE: begin
          if (bus.wb_ack) begin
            wb_count <= wb_count + CW'(1);
            state    <= CLEAR;
          end
        end
        CLEAR: begin
          pend <= pick_in;
          if (pick_valid) begin
            way_sel    <= pick_idx;
            way_sel_oh <= pick_oh;
            state      <= ISSUE;
          end else begin
            state <= NEXT;
          end
        end
        NEXT: begin
          if (set_ctr == LAST_SET) begin
            state <= DONE;
          end else begin
            set_ctr <= set_ctr + AW'(1);
            state   <= READ;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode straight from state so an async reset silences them at once.
  assign flush_busy    = (state != IDLE);
  assign flush_done    = (state == DONE);
  assign bus.dirty_ra  = set_ctr;
  assign bus.wb_req    = (state == ISSUE);
  assign bus.wb_set    = (state == ISSUE) ? set_ctr : '0;
  assign bus.wb_way    = (state == ISSUE) ? way_sel : '0;
  assign bus.dirty_wr  = (state == CLEAR);
  assign bus.dirty_wa  = (state == CLEAR) ? set_ctr : '0;
  assign bus.dirty_way = (state == CLEAR) ? way_sel_oh : '0;
  assign bus.dirty_in  = 1'b0;

endmodule

// File: tb/tb_dirty_flush.sv
// Directed bench for dirty_flush on a 16-set cache with a behavioural
// dirty-bit regfile and a writeback responder with programmable ack delay.
module tb_dirty_flush;

  localparam int SETS = 16;
  localparam int WAYS = 4;
  localparam int AW   = 13;
  localparam int CW   = 16;

  logic          clk;
  logic          reset_n;
  logic          flush_start;
  logic          flush_busy;
  logic          flush_done;
  logic [CW-1:0] wb_count;

  dirty_flush_if #(.AW(AW), .WAYS(WAYS)) bus ();

  dirty_flush #(
    .SETS (SETS),
    .WAYS (WAYS),
    .AW   (AW),
    .CW   (CW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush_start (flush_start),
    .flush_busy  (flush_busy),
    .flush_done  (flush_done),
    .wb_count    (wb_count),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] rf [SETS];
  assign bus.dirty_rd = rf[bus.dirty_ra[3:0]];

  int tests_run;
  int tests_failed;

  int done_cycle, done_pulses, busy_cycles, busy_first, busy_last;
  int nreq, nwr, unstable;
  int req_set [16];
  int req_way [16];
  int req_len [16];
  int wr_set  [16];
  int wr_way  [16];

  task automatic clear_rf();
    for (int i = 0; i < SETS; i++) rf[i] = 4'b0000;
  endtask

  // Runs one flush from the start pulse and records what the DUT did.
  task automatic run_walk(input int ack_delay, input int restart_at, input bit stop_at_req);
    int cyc;
    int req_start;
    bit prev_req;
    done_cycle = -1; done_pulses = 0; busy_cycles = 0; busy_first = -1; busy_last = -1;
    nreq = 0; nwr = 0; unstable = 0; prev_req = 1'b0; req_start = 0;
    bus.wb_ack = (ack_delay == 0);
    @(negedge clk);
    flush_start = 1'b1;
    @(posedge clk);
    cyc = 0;
    for (int k = 0; k < 600; k++) begin
      #1;
      cyc++;
      flush_start = (cyc == restart_at);
      if (flush_busy) begin
        busy_cycles++;
        if (busy_first < 0) busy_first = cyc;
        busy_last = cyc;
      end
      if (flush_done) begin
        done_pulses++;
        if (done_cycle < 0) done_cycle = cyc;
      end
      if (bus.wb_req) begin
        if (!prev_req) begin
          if (nreq < 16) begin
            req_set[nreq] = int'(bus.wb_set);
            req_way[nreq] = int'(bus.wb_way);
            req_len[nreq] = 0;
          end
          nreq++;
          req_start = cyc;
        end else if (nreq <= 16) begin
          if (int'(bus.wb_set) != req_set[nreq-1] || int'(bus.wb_way) != req_way[nreq-1])
            unstable++;
        end
        if (nreq <= 16) req_len[nreq-1]++;
        if (stop_at_req) begin
          bus.wb_ack = 1'b0;
          return;
        end
        bus.wb_ack = ((cyc - req_start) >= ack_delay);
      end else begin
        bus.wb_ack = (ack_delay == 0);
      end
      prev_req = bus.wb_req;
      if (bus.dirty_wr) begin
        if (nwr < 16) begin
          wr_set[nwr] = int'(bus.dirty_wa);
          wr_way[nwr] = int'(bus.dirty_way);
        end
        nwr++;
        rf[bus.dirty_wa[3:0]] = rf[bus.dirty_wa[3:0]] & ~bus.dirty_way;
      end
      if (done_cycle >= 0 && cyc >= done_cycle + 6) break;
      @(posedge clk);
    end
    bus.wb_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; flush_start = 1'b0; bus.wb_ack = 1'b0;
    clear_rf();
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({flush_busy, flush_done, bus.wb_req, bus.dirty_wr, bus.dirty_in} !== 5'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_ctrl: got %b expected 00000",
               {flush_busy, flush_done, bus.wb_req, bus.dirty_wr, bus.dirty_in});
    end
    tests_run++;
    if ({wb_count, bus.dirty_ra, bus.dirty_wa, bus.wb_set} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_buses: wb_count=%0d ra=%0d wa=%0d set=%0d expected all 0",
               wb_count, bus.dirty_ra, bus.dirty_wa, bus.wb_set);
    end
    tests_run++;
    if ({bus.dirty_way, bus.wb_way} !== 6'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_ways: got %b expected 000000", {bus.dirty_way, bus.wb_way});
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_clean_walk();
    clear_rf();
    run_walk(0, -1, 1'b0);
    tests_run++;
    if (done_cycle !== 49) begin tests_failed++; $display("[TB] FAIL clean_done_cycle: got %0d expected 49", done_cycle); end
    tests_run++;
    if (busy_cycles !== 49 || busy_first !== 1 || busy_last !== 49) begin
      tests_failed++;
      $display("[TB] FAIL clean_busy: got %0d cycles %0d..%0d expected 49 cycles 1..49", busy_cycles, busy_first, busy_last);
    end
    tests_run++;
    if (nreq !== 0 || nwr !== 0) begin tests_failed++; $display("[TB] FAIL clean_traffic: got req=%0d wr=%0d expected 0 0", nreq, nwr); end
    tests_run++;
    if (wb_count !== 16'd0) begin tests_failed++; $display("[TB] FAIL clean_wb_count: got %0d expected 0", wb_count); end
    tests_run++;
    if (done_pulses !== 1) begin tests_failed++; $display("[TB] FAIL clean_done_pulses: got %0d expected 1", done_pulses); end
  endtask

  task automatic test_mixed_dirty();
    clear_rf();
    rf[5] = 4'b1010;
    run_walk(0, -1, 1'b0);
    tests_run++;
    if (nreq !== 2) begin tests_failed++; $display("[TB] FAIL mixed_nreq: got %0d expected 2", nreq); end
    tests_run++;
    if (req_set[0] !== 5 || req_way[0] !== 1 || req_set[1] !== 5 || req_way[1] !== 3) begin
      tests_failed++;
      $display("[TB] FAIL mixed_reqs: got (%0d,%0d) (%0d,%0d) expected (5,1) (5,3)", req_set[0], req_way[0], req_set[1], req_way[1]);
    end
    tests_run++;
    if (nwr !== 2 || wr_set[0] !== 5 || wr_way[0] !== 2 || wr_set[1] !== 5 || wr_way[1] !== 8) begin
      tests_failed++;
      $display("[TB] FAIL mixed_writes: got n=%0d (%0d,%0d) (%0d,%0d) expected 2 (5,2) (5,8)", nwr, wr_set[0], wr_way[0], wr_set[1], wr_way[1]);
    end
    tests_run++;
    if (rf[5] !== 4'b0000) begin tests_failed++; $display("[TB] FAIL mixed_rf5: got %b expected 0000", rf[5]); end
    tests_run++;
    if (done_cycle !== 53) begin tests_failed++; $display("[TB] FAIL mixed_done_cycle: got %0d expected 53", done_cycle); end
    tests_run++;
    if (wb_count !== 16'd2) begin tests_failed++; $display("[TB] FAIL mixed_wb_count: got %0d expected 2", wb_count); end
  endtask

  task automatic test_backpressure();
    clear_rf();
    rf[15] = 4'b1111;
    run_walk(3, -1, 1'b0);
    tests_run++;
    if (nreq !== 4) begin tests_failed++; $display("[TB] FAIL bp_nreq: got %0d expected 4", nreq); end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (req_set[i] !== 15 || req_way[i] !== i || req_len[i] !== 4) begin
        tests_failed++;
        $display("[TB] FAIL bp_req%0d: got set=%0d way=%0d len=%0d expected set=15 way=%0d len=4", i, req_set[i], req_way[i], req_len[i], i);
      end
    end
    tests_run++;
    if (unstable !== 0) begin tests_failed++; $display("[TB] FAIL bp_stable: got %0d changes expected 0", unstable); end
    tests_run++;
    if (done_cycle !== 69) begin tests_failed++; $display("[TB] FAIL bp_done_cycle: got %0d expected 69", done_cycle); end
    tests_run++;
    if (wb_count !== 16'd4) begin tests_failed++; $display("[TB] FAIL bp_wb_count: got %0d expected 4", wb_count); end
    tests_run++;
    if (bus.dirty_ra !== 13'd15) begin tests_failed++; $display("[TB] FAIL bp_last_set: got %0d expected 15", bus.dirty_ra); end
    tests_run++;
    if (rf[15] !== 4'b0000) begin tests_failed++; $display("[TB] FAIL bp_rf15: got %b expected 0000", rf[15]); end
  endtask

  task automatic test_busy_start();
    clear_rf();
    run_walk(0, 20, 1'b0);
    tests_run++;
    if (done_pulses !== 1 || done_cycle !== 49) begin
      tests_failed++;
      $display("[TB] FAIL busy_start_done: got %0d pulses first at %0d expected 1 at 49", done_pulses, done_cycle);
    end
    tests_run++;
    if (busy_cycles !== 49) begin tests_failed++; $display("[TB] FAIL busy_start_busy: got %0d expected 49", busy_cycles); end
  endtask

  task automatic test_abort();
    clear_rf();
    rf[3] = 4'b0001;
    run_walk(0, -1, 1'b1);
    tests_run++;
    if (nreq !== 1 || req_set[0] !== 3 || req_way[0] !== 0 || bus.wb_req !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL abort_issue: got n=%0d set=%0d way=%0d req=%b expected 1 3 0 1", nreq, req_set[0], req_way[0], bus.wb_req);
    end
    #2;
    reset_n = 1'b0;
    #1;
    tests_run++;
    if ({bus.wb_req, bus.dirty_wr, flush_busy} !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL abort_async: got req/wr/busy=%b expected 000", {bus.wb_req, bus.dirty_wr, flush_busy});
    end
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus.dirty_wr) rf[bus.dirty_wa[3:0]] = rf[bus.dirty_wa[3:0]] & ~bus.dirty_way;
    end
    tests_run++;
    if (rf[3] !== 4'b0001) begin tests_failed++; $display("[TB] FAIL abort_rf3: got %b expected 0001", rf[3]); end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if (flush_busy !== 1'b0 || wb_count !== 16'd0) begin
      tests_failed++;
      $display("[TB] FAIL abort_idle: got busy=%b wb_count=%0d expected 0 0", flush_busy, wb_count);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_clean_walk();
    test_mixed_dirty();
    test_backpressure();
    test_busy_start();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
